// File: rtl/sram_image_burst.sv
// sram_image_burst: X_MAX x Y_MAX pixel image memory for the FAST corner datapath.
// One pixel can be written per cycle, addressed by (x, y). A read request produces a
// horizontal burst of up to MAX_BURST pixels, streamed out over a valid/ready handshake.
// Out-of-bounds beats are flagged with out_oob. BORDER_MODE 0 returns zero for them, and
// BORDER_MODE 1 clamps each coordinate to the nearest edge pixel.
// Optional macro SRAM_IMAGE_FWD_EN: a write and a burst read that hit the same in-bounds
// pixel in the same cycle return the new write data instead of the old contents.
module sram_image_burst #(
   parameter int unsigned PIXEL_DEPTH = 8,
   parameter int unsigned X_MAX       = 200,
   parameter int unsigned Y_MAX       = 200,
   parameter int unsigned MAX_BURST   = 16,
   parameter int unsigned BORDER_MODE = 0
) (
   input  logic                             ramclk,
   input  logic                             n_rst,
   input  logic                             wen,
   input  logic [$clog2(X_MAX)-1:0]         x_waddr,
   input  logic [$clog2(Y_MAX)-1:0]         y_waddr,
   input  logic [PIXEL_DEPTH-1:0]           wdat,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic [$clog2(X_MAX)-1:0]         x_addr,
   input  logic [$clog2(Y_MAX)-1:0]         y_addr,
   input  logic [$clog2(MAX_BURST+1)-1:0]   burst_len,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [PIXEL_DEPTH-1:0]           rdat,
   output logic                             out_last,
   output logic                             out_oob,
   output logic                             busy
);

   localparam int unsigned XW    = $clog2(X_MAX);
   localparam int unsigned YW    = $clog2(Y_MAX);
   localparam int unsigned LW    = $clog2(MAX_BURST + 1);
   localparam int unsigned BW    = $clog2(MAX_BURST);
   // Beat x sum is wide enough that x_addr + beat index never wraps.
   localparam int unsigned SW    = XW + BW + 1;
   localparam int unsigned DEPTH = X_MAX * Y_MAX;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned FW    = PIXEL_DEPTH + 2;

   // Limits are one bit wider than the coordinate so power-of-two sizes still compare.
   localparam logic [SW-1:0] X_LIM_BEAT = SW'(X_MAX);
   localparam logic [XW:0]   X_LIM_WR   = (XW + 1)'(X_MAX);
   localparam logic [YW:0]   Y_LIM      = (YW + 1)'(Y_MAX);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain
   } state_t;

   // Pixel storage, row-major; never reset.
   logic [PIXEL_DEPTH-1:0] r_mem [DEPTH];

   state_t                 r_state;
   state_t                 w_state_next;

   // Latched request.
   logic [XW-1:0]          r_x;
   logic [YW-1:0]          r_y;
   logic [LW-1:0]          r_len;
   logic [LW-1:0]          r_beat;
   logic [LW-1:0]          w_len_eff;

   // Read stage between the memory and the output FIFO.
   logic                   r_rd_vld;
   logic                   r_rd_last;
   logic                   r_rd_oob;
   logic [PIXEL_DEPTH-1:0] r_rd_data;

   // Two-entry output FIFO; slot 0 is always the head.
   logic [FW-1:0]          r_slot0;
   logic [FW-1:0]          r_slot1;
   logic [1:0]             r_cnt;

   logic                   w_accept;
   logic                   w_issue;
   logic                   w_pop;
   logic [1:0]             w_occ_np;
   logic                   w_credit;
   logic [FW-1:0]          w_push_word;

   logic [SW-1:0]          w_bx;
   logic                   w_x_oob;
   logic                   w_y_oob;
   logic                   w_beat_oob;
   logic                   w_beat_last;
   logic                   w_rd_zero;
   logic [XW-1:0]          w_cx;
   logic [YW-1:0]          w_cy;
   logic [AW-1:0]          w_rd_idx;

   logic                   w_wr_ok;
   logic [AW-1:0]          w_wr_idx;

   // ---------------------------------------------------------------------------------
   // Write address decode: out-of-bounds writes are dropped.
   // ---------------------------------------------------------------------------------
   assign w_wr_ok  = wen && ({1'b0, x_waddr} < X_LIM_WR) && ({1'b0, y_waddr} < Y_LIM);
   assign w_wr_idx = AW'(y_waddr) * AW'(X_MAX) + AW'(x_waddr);

   // ---------------------------------------------------------------------------------
   // Beat address: current beat x, bounds test, clamp and linear index.
   // ---------------------------------------------------------------------------------
   assign w_bx        = SW'(r_x) + SW'(r_beat);
   assign w_x_oob     = (w_bx >= X_LIM_BEAT);
   assign w_y_oob     = ({1'b0, r_y} >= Y_LIM);
   assign w_beat_oob  = w_x_oob | w_y_oob;
   assign w_beat_last = (r_beat == (r_len - LW'(1)));
   // Clamped coordinates keep the memory index in range in both border modes.
   assign w_cx        = w_x_oob ? XW'(X_MAX - 1) : w_bx[XW-1:0];
   assign w_cy        = w_y_oob ? YW'(Y_MAX - 1) : r_y;
   assign w_rd_idx    = AW'(w_cy) * AW'(X_MAX) + AW'(w_cx);
   assign w_rd_zero   = (BORDER_MODE == 0) && w_beat_oob;

   // ---------------------------------------------------------------------------------
   // FIFO occupancy and read credit. A pop in this cycle frees its slot for an issue
   // in the same cycle, which keeps a streaming burst free of bubbles.
   // ---------------------------------------------------------------------------------
   assign w_pop       = (r_cnt != 2'd0) && out_ready;
   assign w_occ_np    = r_cnt - {1'b0, w_pop};
   assign w_credit    = (w_occ_np == 2'd0) || ((w_occ_np == 2'd1) && !r_rd_vld);
   assign w_push_word = {r_rd_oob, r_rd_last, r_rd_data};

   // Requested length normalised: zero means one beat, long requests clamp to MAX_BURST.
   always_comb begin
      w_len_eff = burst_len;
      if (burst_len == '0) begin
         w_len_eff = LW'(1);
      end else if (burst_len > LW'(MAX_BURST)) begin
         w_len_eff = LW'(MAX_BURST);
      end
   end

   // Next-state and strobe decode for the burst engine.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_issue      = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (req_valid) begin
               w_accept     = 1'b1;
               w_state_next = StIssue;
            end
         end
         StIssue: begin
            if (w_credit) begin
               w_issue = 1'b1;
               if (w_beat_last) begin
                  w_state_next = StDrain;
               end
            end
         end
         StDrain: begin
            // Leave once the last beat has been handed over this cycle.
            if (!r_rd_vld && (w_occ_np == 2'd0)) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Burst engine state register.
   always_ff @(posedge ramclk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Request latch, beat counter and read-stage sideband.
   always_ff @(posedge ramclk or negedge n_rst) begin
      if (!n_rst) begin
         r_x       <= '0;
         r_y       <= '0;
         r_len     <= '0;
         r_beat    <= '0;
         r_rd_vld  <= 1'b0;
         r_rd_last <= 1'b0;
         r_rd_oob  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_x    <= x_addr;
            r_y    <= y_addr;
            r_len  <= w_len_eff;
            r_beat <= '0;
         end else if (w_issue) begin
            r_beat <= r_beat + LW'(1);
         end
         r_rd_vld <= w_issue;
         if (w_issue) begin
            r_rd_last <= w_beat_last;
            r_rd_oob  <= w_beat_oob;
         end
      end
   end

   // Memory port: pixel write plus one synchronous burst read per issued beat.
   always_ff @(posedge ramclk) begin
      if (w_wr_ok) begin
         r_mem[w_wr_idx] <= wdat;
      end
      if (w_issue) begin
         if (w_rd_zero) begin
            r_rd_data <= '0;
`ifdef SRAM_IMAGE_FWD_EN
         end else if (w_wr_ok && !w_beat_oob && (w_wr_idx == w_rd_idx)) begin
            r_rd_data <= wdat;
`endif
         end else begin
            r_rd_data <= r_mem[w_rd_idx];
         end
      end
   end

   // Output FIFO: pop shifts slot 1 to the head; push lands in the first free slot.
   always_ff @(posedge ramclk or negedge n_rst) begin
      if (!n_rst) begin
         r_slot0 <= '0;
         r_slot1 <= '0;
         r_cnt   <= 2'd0;
      end else begin
         if (w_pop) begin
            r_slot0 <= r_slot1;
         end
         if (r_rd_vld) begin
            if (w_occ_np == 2'd0) begin
               r_slot0 <= w_push_word;
            end else begin
               r_slot1 <= w_push_word;
            end
         end
         r_cnt <= w_occ_np + {1'b0, r_rd_vld};
      end
   end

   assign req_ready                 = (r_state == StIdle);
   assign out_valid                 = (r_cnt != 2'd0);
   assign {out_oob, out_last, rdat} = r_slot0;
   assign busy                      = (r_state != StIdle) | out_valid;

endmodule

// File: tb/tb_sram_image_burst.sv
// Directed bench for sram_image_burst: reset values, streaming latency, length
// normalisation, border beats, dropped writes, backpressure, same-cycle write/read and
// reset in the middle of a burst.
module tb_sram_image_burst;

   localparam int PD = 8;
   localparam int XM = 200;
   localparam int YM = 200;
   localparam int MB = 16;
   localparam int BM = 0;
   localparam int XW = $clog2(XM);
   localparam int YW = $clog2(YM);
   localparam int LW = $clog2(MB + 1);

   logic          ramclk = 1'b0;
   logic          n_rst = 1'b0;
   logic          wen = 1'b0;
   logic [XW-1:0] x_waddr = '0;
   logic [YW-1:0] y_waddr = '0;
   logic [PD-1:0] wdat = '0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [XW-1:0] x_addr = '0;
   logic [YW-1:0] y_addr = '0;
   logic [LW-1:0] burst_len = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [PD-1:0] rdat;
   logic          out_last;
   logic          out_oob;
   logic          busy;

   sram_image_burst #(
      .PIXEL_DEPTH (PD),
      .X_MAX       (XM),
      .Y_MAX       (YM),
      .MAX_BURST   (MB),
      .BORDER_MODE (BM)
   ) dut (
      .ramclk    (ramclk),
      .n_rst     (n_rst),
      .wen       (wen),
      .x_waddr   (x_waddr),
      .y_waddr   (y_waddr),
      .wdat      (wdat),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .x_addr    (x_addr),
      .y_addr    (y_addr),
      .burst_len (burst_len),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rdat      (rdat),
      .out_last  (out_last),
      .out_oob   (out_oob),
      .busy      (busy)
   );

   always #5 ramclk = ~ramclk;

   int err = 0;
   int chk = 0;

   // Beats captured by the last burst.
   int b_dat [32];
   bit b_last [32];
   bit b_oob [32];
   int b_k [32];
   int n_beats;
   int first_k;
   int rr_k;
   int rr_beats;
   int n_unstable;

   task automatic write_px(input int x, input int y, input int d);
      wen     = 1'b1;
      x_waddr = XW'(x);
      y_waddr = YW'(y);
      wdat    = PD'(d);
      @(posedge ramclk);
      #1;
      wen = 1'b0;
   endtask

   // Issue one request and collect beats; k counts edges after acceptance (E0).
   // stall selects out_ready pattern 1,0,0,1,...; wr drives a write in the E0..E1 cycle.
   task automatic burst(input int bx, input int by, input int blen, input bit stall,
                        input bit wr, input int wx, input int wy, input int wd);
      logic          pv;
      logic          pr;
      logic [PD+1:0] pw;
      for (int i = 0; i < 32; i++) begin
         b_dat[i]  = -1;
         b_last[i] = 1'b0;
         b_oob[i]  = 1'b0;
         b_k[i]    = -1;
      end
      n_beats    = 0;
      first_k    = -1;
      rr_k       = -1;
      rr_beats   = -1;
      n_unstable = 0;
      x_addr     = XW'(bx);
      y_addr     = YW'(by);
      burst_len  = LW'(blen);
      req_valid  = 1'b1;
      @(posedge ramclk);
      #1;
      req_valid = 1'b0;
      if (wr) begin
         wen     = 1'b1;
         x_waddr = XW'(wx);
         y_waddr = YW'(wy);
         wdat    = PD'(wd);
      end
      pv = 1'b0;
      pr = 1'b0;
      pw = '0;
      for (int k = 0; k < 80; k++) begin
         if (k > 0) begin
            @(posedge ramclk);
            #1;
            wen = 1'b0;
         end
         out_ready = stall ? (((k % 4) == 0) || ((k % 4) == 3)) : 1'b1;
         if (pv && !pr && (!out_valid || ({out_oob, out_last, rdat} !== pw))) n_unstable++;
         if ((k > 0) && req_ready && !out_valid) begin
            rr_k     = k;
            rr_beats = n_beats;
            break;
         end
         if (out_valid) begin
            if (first_k < 0) first_k = k;
            if (out_ready && (n_beats < 32)) begin
               b_dat[n_beats]  = int'(rdat);
               b_last[n_beats] = out_last;
               b_oob[n_beats]  = out_oob;
               b_k[n_beats]    = k;
               n_beats++;
            end
         end
         pv = out_valid;
         pr = out_ready;
         pw = {out_oob, out_last, rdat};
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset;
      n_rst = 1'b0;
      repeat (2) @(posedge ramclk);
      #1;
      chk++; if (req_ready !== 1'b1) begin err++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
      chk++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      chk++; if (rdat !== '0) begin err++; $display("FAIL reset_rdat got %0h want 0", rdat); end
      chk++; if (out_last !== 1'b0) begin err++; $display("FAIL reset_out_last got %0b want 0", out_last); end
      chk++; if (out_oob !== 1'b0) begin err++; $display("FAIL reset_out_oob got %0b want 0", out_oob); end
      chk++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got %0b want 0", busy); end
      n_rst = 1'b1;
      @(posedge ramclk);
      #1;
   endtask

   task automatic preload;
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++) write_px(x, y, y * 16 + x);
      for (int i = 0; i < 4; i++) write_px(196 + i, 5, 196 + i);
      write_px(20, 199, 'h3C);
      write_px(55, 1, 'h5A);
      write_px(16, 2, 'h77);
   endtask

   task automatic test_burst_row;
      burst(0, 3, 16, 1'b0, 1'b0, 0, 0, 0);
      chk++; if (first_k !== 2) begin err++; $display("FAIL row_first_valid edge got %0d want 2", first_k); end
      chk++; if (n_beats !== 16) begin err++; $display("FAIL row_count got %0d want 16", n_beats); end
      for (int i = 0; i < 16; i++) begin
         chk++;
         if (b_dat[i] !== 48 + i || b_k[i] !== 2 + i || b_last[i] !== (i == 15) || b_oob[i] !== 1'b0) begin
            err++;
            $display("FAIL row_beat %0d got d=%0d k=%0d l=%0b o=%0b want d=%0d k=%0d l=%0b o=0",
                     i, b_dat[i], b_k[i], b_last[i], b_oob[i], 48 + i, 2 + i, (i == 15));
         end
      end
      chk++; if (rr_k !== 18) begin err++; $display("FAIL row_req_ready edge got %0d want 18", rr_k); end
   endtask

   task automatic test_small_write;
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++) write_px(x, y, (x + 1) * (y + 1) * 4);
      burst(0, 2, 4, 1'b0, 1'b0, 0, 0, 0);
      chk++; if (n_beats !== 4) begin err++; $display("FAIL small_count got %0d want 4", n_beats); end
      for (int i = 0; i < 4; i++) begin
         chk++;
         if (b_dat[i] !== (i + 1) * 12 || b_last[i] !== (i == 3)) begin
            err++;
            $display("FAIL small_beat %0d got d=%0d l=%0b want d=%0d l=%0b",
                     i, b_dat[i], b_last[i], (i + 1) * 12, (i == 3));
         end
      end
      chk++; if (rr_k !== 6) begin err++; $display("FAIL small_req_ready edge got %0d want 6", rr_k); end
   endtask

   task automatic test_len_clamp;
      burst(0, 2, 0, 1'b0, 1'b0, 0, 0, 0);
      chk++;
      if (n_beats !== 1 || b_dat[0] !== 12 || b_last[0] !== 1'b1) begin
         err++;
         $display("FAIL len_zero got n=%0d d=%0d l=%0b want n=1 d=12 l=1", n_beats, b_dat[0], b_last[0]);
      end
      burst(0, 5, 20, 1'b0, 1'b0, 0, 0, 0);
      chk++; if (n_beats !== 16) begin err++; $display("FAIL len_clamp_count got %0d want 16", n_beats); end
      for (int i = 0; i < 16; i++) begin
         chk++;
         if (b_dat[i] !== 80 + i || b_last[i] !== (i == 15)) begin
            err++;
            $display("FAIL len_clamp_beat %0d got d=%0d l=%0b want d=%0d l=%0b",
                     i, b_dat[i], b_last[i], 80 + i, (i == 15));
         end
      end
   endtask

   task automatic test_border;
      int e;
      burst(196, 5, 8, 1'b0, 1'b0, 0, 0, 0);
      chk++; if (n_beats !== 8) begin err++; $display("FAIL border_count got %0d want 8", n_beats); end
      for (int i = 0; i < 8; i++) begin
         e = (i < 4) ? 196 + i : ((BM == 1) ? 199 : 0);
         chk++;
         if (b_dat[i] !== e || b_oob[i] !== (i >= 4) || b_last[i] !== (i == 7)) begin
            err++;
            $display("FAIL border_beat %0d got d=%0d o=%0b l=%0b want d=%0d o=%0b l=%0b",
                     i, b_dat[i], b_oob[i], b_last[i], e, (i >= 4), (i == 7));
         end
      end
   endtask

   task automatic test_far_oob;
      int e;
      e = (BM == 1) ? 'h3C : 0;
      burst(20, 254, 2, 1'b0, 1'b0, 0, 0, 0);
      chk++; if (n_beats !== 2) begin err++; $display("FAIL far_count got %0d want 2", n_beats); end
      for (int i = 0; i < 2; i++) begin
         chk++;
         if (b_dat[i] !== e || b_oob[i] !== 1'b1) begin
            err++;
            $display("FAIL far_beat %0d got d=%0h o=%0b want d=%0h o=1", i, b_dat[i], b_oob[i], e);
         end
      end
      // x=255 at row 0 would alias pixel (55,1) if the bounds test were missing.
      write_px(255, 0, 'hEE);
      burst(55, 1, 1, 1'b0, 1'b0, 0, 0, 0);
      chk++;
      if (b_dat[0] !== 'h5A || b_oob[0] !== 1'b0) begin
         err++;
         $display("FAIL oob_write_dropped got d=%0h o=%0b want d=5a o=0", b_dat[0], b_oob[0]);
      end
   endtask

   task automatic test_backpressure;
      int exp_bp [8];
      exp_bp = '{4, 8, 12, 16, 4, 5, 6, 7};
      burst(0, 0, 8, 1'b1, 1'b0, 0, 0, 0);
      chk++; if (n_beats !== 8) begin err++; $display("FAIL bp_count got %0d want 8", n_beats); end
      for (int i = 0; i < 8; i++) begin
         chk++;
         if (b_dat[i] !== exp_bp[i] || b_last[i] !== (i == 7)) begin
            err++;
            $display("FAIL bp_beat %0d got d=%0d l=%0b want d=%0d l=%0b",
                     i, b_dat[i], b_last[i], exp_bp[i], (i == 7));
         end
      end
      chk++; if (n_unstable !== 0) begin err++; $display("FAIL bp_stable got %0d changes want 0", n_unstable); end
      chk++; if (rr_beats !== 8) begin err++; $display("FAIL bp_req_ready_early got %0d beats want 8", rr_beats); end
   endtask

   task automatic test_raw;
      int e;
`ifdef SRAM_IMAGE_FWD_EN
      e = 'hAD;
`else
      e = 'h77;
`endif
      burst(16, 2, 1, 1'b0, 1'b1, 16, 2, 'hAD);
      chk++; if (b_dat[0] !== e) begin err++; $display("FAIL raw_same_cycle got %0h want %0h", b_dat[0], e); end
      burst(16, 2, 1, 1'b0, 1'b0, 0, 0, 0);
      chk++; if (b_dat[0] !== 'hAD) begin err++; $display("FAIL raw_after got %0h want ad", b_dat[0]); end
   endtask

   task automatic test_reset_mid;
      x_addr    = XW'(0);
      y_addr    = YW'(5);
      burst_len = LW'(16);
      out_ready = 1'b1;
      req_valid = 1'b1;
      @(posedge ramclk);
      #1;
      req_valid = 1'b0;
      repeat (3) @(posedge ramclk);
      #1;
      chk++; if (out_valid !== 1'b1) begin err++; $display("FAIL mid_streaming got %0b want 1", out_valid); end
      n_rst = 1'b0;
      #1;
      chk++; if (out_valid !== 1'b0) begin err++; $display("FAIL mid_out_valid got %0b want 0", out_valid); end
      chk++; if (req_ready !== 1'b1) begin err++; $display("FAIL mid_req_ready got %0b want 1", req_ready); end
      chk++; if (busy !== 1'b0) begin err++; $display("FAIL mid_busy got %0b want 0", busy); end
      chk++; if (rdat !== '0) begin err++; $display("FAIL mid_rdat got %0h want 0", rdat); end
      @(posedge ramclk);
      #1;
      n_rst = 1'b1;
      @(posedge ramclk);
      #1;
      burst(16, 2, 1, 1'b0, 1'b0, 0, 0, 0);
      chk++; if (b_dat[0] !== 'hAD) begin err++; $display("FAIL mid_mem_kept got %0h want ad", b_dat[0]); end
   endtask

   initial begin
      test_reset;
      preload;
      test_burst_row;
      test_small_write;
      test_len_clamp;
      test_border;
      test_far_oob;
      test_backpressure;
      test_raw;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", err, chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
